// File: rtl/fpu_cmd_sequencer_if.sv
// Command, FPU and response signal bundle of the FPU command sequencer.
// slave is the sequencer's view; master is the surrounding system (bus + FPU).
interface fpu_cmd_sequencer_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned OP_BITS = 2,
  parameter int unsigned DEPTH   = 4
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [WIDTH-1:0]   cmd_a;
  logic [WIDTH-1:0]   cmd_b;
  logic [OP_BITS-1:0] cmd_op;

  logic               fpu_start;
  logic [WIDTH-1:0]   fpu_inpA;
  logic [WIDTH-1:0]   fpu_inpB;
  logic [OP_BITS-1:0] fpu_operation;
  logic [WIDTH-1:0]   fpu_res;
  logic               fpu_ready;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_data;
  logic               rsp_timeout;
  logic               err_halt;
  logic [LVL_W-1:0]   fifo_level;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, fpu_res, fpu_ready, rsp_ready,
    output cmd_ready, fpu_start, fpu_inpA, fpu_inpB, fpu_operation,
           rsp_valid, rsp_data, rsp_timeout, err_halt, fifo_level
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, fpu_res, fpu_ready, rsp_ready,
    input  cmd_ready, fpu_start, fpu_inpA, fpu_inpB, fpu_operation,
           rsp_valid, rsp_data, rsp_timeout, err_halt, fifo_level
  );
endinterface

// File: rtl/fpu_cmd_sequencer.sv
// Initiator side of the FPU start/ready handshake: command FIFO, one-shot issue,
// guarded wait with timeout, and a held valid/ready response.
module fpu_cmd_sequencer #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned OP_BITS = 2,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  fpu_cmd_sequencer_if.slave    bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GUARD,
    S_WAIT,
    S_HALT
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]   mem_a_q  [DEPTH];
  logic [WIDTH-1:0]   mem_b_q  [DEPTH];
  logic [OP_BITS-1:0] mem_op_q [DEPTH];

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               fpu_start_q, fpu_start_d;
  logic [WIDTH-1:0]   inp_a_q, inp_a_d;
  logic [WIDTH-1:0]   inp_b_q, inp_b_d;
  logic [OP_BITS-1:0] op_q, op_d;

  logic               rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic               rsp_timeout_q, rsp_timeout_d;
  logic               err_halt_q, err_halt_d;

  logic               push;
  logic               pop;

  // Next-state, FIFO bookkeeping and registered-output computation
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    cnt_d         = cnt_q;
    fpu_start_d   = 1'b0;
    inp_a_d       = inp_a_q;
    inp_b_d       = inp_b_q;
    op_d          = op_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    err_halt_d    = err_halt_q;
    push          = bus.cmd_valid & cmd_ready_q;
    pop           = 1'b0;

    if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if ((level_q != '0) && !rsp_valid_q) begin
          pop         = 1'b1;
          inp_a_d     = mem_a_q[rd_ptr_q];
          inp_b_d     = mem_b_q[rd_ptr_q];
          op_d        = mem_op_q[rd_ptr_q];
          fpu_start_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_GUARD;
      // One dead cycle so a ready left over from the previous op is never captured
      S_GUARD: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.fpu_ready) begin
          rsp_data_d    = bus.fpu_res;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = S_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          err_halt_d    = 1'b1;
          state_d       = S_HALT;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    level_d     = level_q + LVL_W'(push) - LVL_W'(pop);
    cmd_ready_d = (level_d != LVL_W'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      cmd_ready_q   <= 1'b1;
      cnt_q         <= '0;
      fpu_start_q   <= 1'b0;
      inp_a_q       <= '0;
      inp_b_q       <= '0;
      op_q          <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      err_halt_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      cmd_ready_q   <= cmd_ready_d;
      cnt_q         <= cnt_d;
      fpu_start_q   <= fpu_start_d;
      inp_a_q       <= inp_a_d;
      inp_b_q       <= inp_b_d;
      op_q          <= op_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      err_halt_q    <= err_halt_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and level
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q]  <= bus.cmd_a;
      mem_b_q[wr_ptr_q]  <= bus.cmd_b;
      mem_op_q[wr_ptr_q] <= bus.cmd_op;
    end
  end

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.fpu_start     = fpu_start_q;
  assign bus.fpu_inpA      = inp_a_q;
  assign bus.fpu_inpB      = inp_b_q;
  assign bus.fpu_operation = op_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_timeout   = rsp_timeout_q;
  assign bus.err_halt      = err_halt_q;
  assign bus.fifo_level    = level_q;
endmodule
